// File: rtl/gigatron_input_arbiter.sv
// gigatron_input_arbiter
//   Emulates a Famicom shift-register pad for the Gigatron and decides, one
//   latch frame at a time, whether the MiSTer joystick byte or a keyboard
//   ASCII byte is presented. A keystroke owns the port for KEY_HOLD_FRAMES
//   frames, followed by KEY_GAP_FRAMES frames of released (0xFF).
//
//   Build option: define INPUT_ARB_KEY_FIFO_EN to replace the single
//   keystroke holding register with a 4-entry FIFO.

module gigatron_input_arbiter #(
    parameter int KEY_HOLD_FRAMES = 3,  // 1..15
    parameter int KEY_GAP_FRAMES  = 1   // 1..15
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] joy_buttons,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    input  logic       famicom_latch,
    input  logic       famicom_pulse,
    output logic       famicom_data,
    output logic       key_active
);

    typedef enum logic [1:0] {
        ST_JOY = 2'd0,
        ST_KEY = 2'd1,
        ST_GAP = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_RELOAD = 4'(KEY_HOLD_FRAMES - 1);
    localparam logic [3:0] GAP_RELOAD  = 4'(KEY_GAP_FRAMES - 1);

    // ------------------------------------------------------------------
    // Pin synchronizers and rising-edge detectors
    // ------------------------------------------------------------------
    logic latch_meta, latch_sync, latch_prev;
    logic pulse_meta, pulse_sync, pulse_prev;
    logic latch_rise, pulse_rise;

    // Two-stage synchronizers plus one history stage for edge detection.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, whatever the statement order.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            latch_meta <= 1'b0;
            latch_sync <= 1'b0;
            latch_prev <= 1'b0;
            pulse_meta <= 1'b0;
            pulse_sync <= 1'b0;
            pulse_prev <= 1'b0;
        end else begin
            latch_meta <= famicom_latch;
            latch_sync <= latch_meta;
            latch_prev <= latch_sync;
            pulse_meta <= famicom_pulse;
            pulse_sync <= pulse_meta;
            pulse_prev <= pulse_sync;
        end
    end

    assign latch_rise = latch_sync & ~latch_prev;
    assign pulse_rise = pulse_sync & ~pulse_prev;

    // ------------------------------------------------------------------
    // Keystroke storage
    // ------------------------------------------------------------------
    state_t     state;
    logic [3:0] frame_cnt;
    logic [7:0] sr;
    logic [7:0] key_byte;

    logic       key_accept;
    logic       key_consume;
    logic       key_pending;
    logic [7:0] key_head;

    assign key_accept = key_valid & key_ready;

    // A pending key is taken on the frame tick that enters KEY, either from
    // idle or at the end of a gap.
    assign key_consume = latch_rise & key_pending &
                         ((state == ST_JOY) ||
                          ((state == ST_GAP) && (frame_cnt == 4'd0)));

`ifdef INPUT_ARB_KEY_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_count;

    assign key_pending = (fifo_count != 3'd0);
    assign key_head    = fifo_mem[rd_ptr];
    assign key_ready   = (fifo_count != 3'd4);

    // FIFO data array.
    // NOTE: storage is not reset; validity is tracked entirely by the pointers
    // and count, which keeps the array a plain RAM.
    always_ff @(posedge clk_sys) begin
        if (key_accept) begin
            fifo_mem[wr_ptr] <= key_code;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (key_accept)  wr_ptr <= wr_ptr + 2'd1;
            if (key_consume) rd_ptr <= rd_ptr + 2'd1;
            case ({key_accept, key_consume})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
`else
    logic [7:0] hold_byte;
    logic       hold_full;

    assign key_pending = hold_full;
    assign key_head    = hold_byte;
    assign key_ready   = ~hold_full;

    // Single holding register; freed as soon as its byte moves into key_byte,
    // so the next key can be taken during KEY/GAP. Accept and consume are
    // mutually exclusive because accept needs it empty and consume needs it full.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hold_byte <= 8'h00;
            hold_full <= 1'b0;
        end else if (key_accept) begin
            hold_byte <= key_code;
            hold_full <= 1'b1;
        end else if (key_consume) begin
            hold_full <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Frame scheduler and shift register
    // ------------------------------------------------------------------
    // Frame FSM advances only on latch ticks; the same tick loads the byte of
    // the state being entered. Pulses shift only while latch is low, and a
    // latch tick takes precedence over a coincident pulse.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= ST_JOY;
            frame_cnt <= 4'd0;
            sr        <= 8'hFF;
            key_byte  <= 8'h00;
        end else if (latch_rise) begin
            case (state)
                ST_JOY: begin
                    if (key_pending) begin
                        state     <= ST_KEY;
                        frame_cnt <= HOLD_RELOAD;
                        key_byte  <= key_head;
                        sr        <= key_head;
                    end else begin
                        sr <= ~joy_buttons;
                    end
                end
                ST_KEY: begin
                    if (frame_cnt == 4'd0) begin
                        state     <= ST_GAP;
                        frame_cnt <= GAP_RELOAD;
                        sr        <= 8'hFF;
                    end else begin
                        frame_cnt <= frame_cnt - 4'd1;
                        sr        <= key_byte;
                    end
                end
                ST_GAP: begin
                    if (frame_cnt != 4'd0) begin
                        frame_cnt <= frame_cnt - 4'd1;
                        sr        <= 8'hFF;
                    end else if (key_pending) begin
                        state     <= ST_KEY;
                        frame_cnt <= HOLD_RELOAD;
                        key_byte  <= key_head;
                        sr        <= key_head;
                    end else begin
                        state <= ST_JOY;
                        sr    <= ~joy_buttons;
                    end
                end
                default: begin
                    state     <= ST_JOY;
                    frame_cnt <= 4'd0;
                    sr        <= 8'hFF;
                end
            endcase
        end else if (pulse_rise && !latch_sync) begin
            sr <= {sr[6:0], 1'b1};
        end
    end

    assign famicom_data = sr[7];
    assign key_active   = (state == ST_KEY);

endmodule

// File: tb/tb_gigatron_input_arbiter.sv
// tb_gigatron_input_arbiter
//   Directed bench for gigatron_input_arbiter with default parameters.
//   Joystick frames come from a vector table; keystroke scheduling, edge
//   priority, latency and mid-hold reset use hand-written sequences.
//   Handles both the default build and INPUT_ARB_KEY_FIFO_EN.

module tb_gigatron_input_arbiter;

    logic       clk_sys;
    logic       reset_n;
    logic [7:0] joy_buttons;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic       famicom_latch;
    logic       famicom_pulse;
    logic       famicom_data;
    logic       key_active;

    int errors = 0;
    int checks = 0;

    gigatron_input_arbiter dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .joy_buttons   (joy_buttons),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data),
        .key_active    (key_active)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] joy;
        logic [7:0] exp_byte;
    } joy_vec_t;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // One full Gigatron read: latch, read MSB, 7 pulses for the remaining
    // bits, then one extra pulse to observe the shifted-in 1.
    task automatic read_frame(output logic [7:0] b, output logic act,
                              output logic tail);
        b = 8'h00;
        famicom_latch = 1'b1;
        wait_cycles(4);
        b[7] = famicom_data;
        act  = key_active;
        famicom_latch = 1'b0;
        wait_cycles(4);
        for (int i = 6; i >= 0; i--) begin
            famicom_pulse = 1'b1;
            wait_cycles(4);
            famicom_pulse = 1'b0;
            wait_cycles(4);
            b[i] = famicom_data;
        end
        famicom_pulse = 1'b1;
        wait_cycles(4);
        famicom_pulse = 1'b0;
        wait_cycles(4);
        tail = famicom_data;
    endtask

    task automatic send_key(input logic [7:0] code);
        int budget;
        budget = 0;
        while (!key_ready && budget < 200) begin
            @(negedge clk_sys);
            budget++;
        end
        if (!key_ready) begin
            check("key_ready_timeout", 32'(key_ready), 32'd1);
        end else begin
            key_valid = 1'b1;
            key_code  = code;
            @(negedge clk_sys);
            key_valid = 1'b0;
        end
    endtask

    initial begin
        joy_vec_t   vecs [5];
        logic [7:0] seq_byte [9];
        logic       seq_act  [9];
        logic [7:0] b;
        logic       act;
        logic       tail;

        vecs[0] = '{joy: 8'h00, exp_byte: 8'hFF};
        vecs[1] = '{joy: 8'h81, exp_byte: 8'h7E};
        vecs[2] = '{joy: 8'hFF, exp_byte: 8'h00};
        vecs[3] = '{joy: 8'h5A, exp_byte: 8'hA5};
        vecs[4] = '{joy: 8'h3C, exp_byte: 8'hC3};

        reset_n       = 1'b0;
        joy_buttons   = 8'h00;
        key_valid     = 1'b0;
        key_code      = 8'h00;
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;
        wait_cycles(4);
        check("reset_data",   32'(famicom_data), 32'd1);
        check("reset_ready",  32'(key_ready),    32'd1);
        check("reset_active", 32'(key_active),   32'd0);
        reset_n = 1'b1;
        wait_cycles(2);

        // Joystick frames from the vector table.
        foreach (vecs[i]) begin
            joy_buttons = vecs[i].joy;
            read_frame(b, act, tail);
            check($sformatf("joy_byte[%0d]", i), 32'(b), 32'(vecs[i].exp_byte));
            check($sformatf("joy_active[%0d]", i), 32'(act), 32'd0);
            check($sformatf("joy_tail[%0d]", i), 32'(tail), 32'd1);
        end

        // Latch latency: unchanged two clocks after the pin edge, loaded on
        // the third. Then a pulse while latch is high must not shift.
        joy_buttons   = 8'h81;
        famicom_latch = 1'b1;
        wait_cycles(2);
        check("latency_early", 32'(famicom_data), 32'd1);
        wait_cycles(1);
        check("latency_load", 32'(famicom_data), 32'd0);
        famicom_pulse = 1'b1;
        wait_cycles(4);
        famicom_pulse = 1'b0;
        wait_cycles(4);
        check("pulse_latch_high", 32'(famicom_data), 32'd0);
        famicom_latch = 1'b0;
        wait_cycles(4);
        famicom_pulse = 1'b1;
        wait_cycles(4);
        famicom_pulse = 1'b0;
        wait_cycles(4);
        check("after_latch_bit6", 32'(famicom_data), 32'd1);

        // Coincident latch and pulse edges: load wins, MSB first.
        read_frame(b, act, tail);  // flush to all ones
        famicom_latch = 1'b1;
        famicom_pulse = 1'b1;
        wait_cycles(4);
        check("simul_msb", 32'(famicom_data), 32'd0);
        famicom_pulse = 1'b0;
        famicom_latch = 1'b0;
        wait_cycles(4);
        famicom_pulse = 1'b1;
        wait_cycles(4);
        famicom_pulse = 1'b0;
        wait_cycles(4);
        check("simul_bit6", 32'(famicom_data), 32'd1);
        read_frame(b, act, tail);  // finish the frame, stays in JOY

        // Keystroke 'A': 3 key frames, 1 gap, then joystick (0x81 -> 0x7E).
        send_key(8'h41);
        @(negedge clk_sys);
`ifndef INPUT_ARB_KEY_FIFO_EN
        check("ready_after_accept", 32'(key_ready), 32'd0);
`endif
        for (int f = 0; f < 5; f++) begin
            read_frame(b, act, tail);
            check($sformatf("keyA_byte[%0d]", f), 32'(b),
                  (f < 3) ? 32'h41 : ((f == 3) ? 32'hFF : 32'h7E));
            check($sformatf("keyA_active[%0d]", f), 32'(act),
                  (f < 3) ? 32'd1 : 32'd0);
        end

        // Back-to-back 'h','i'.
        seq_byte = '{8'h68, 8'h68, 8'h68, 8'hFF, 8'h69, 8'h69, 8'h69, 8'hFF, 8'h7E};
        seq_act  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef INPUT_ARB_KEY_FIFO_EN
        key_valid = 1'b1;
        key_code  = 8'h68;
        @(negedge clk_sys);
        check("fifo_ready_2nd", 32'(key_ready), 32'd1);
        key_code  = 8'h69;
        @(negedge clk_sys);
        key_valid = 1'b0;
`else
        send_key(8'h68);
        check("hold_blocks_2nd", 32'(key_ready), 32'd0);
`endif
        for (int f = 0; f < 9; f++) begin
            read_frame(b, act, tail);
            check($sformatf("hi_byte[%0d]", f), 32'(b), 32'(seq_byte[f]));
            check($sformatf("hi_active[%0d]", f), 32'(act), 32'(seq_act[f]));
`ifndef INPUT_ARB_KEY_FIFO_EN
            if (f == 0) begin
                check("hold_freed", 32'(key_ready), 32'd1);
                send_key(8'h69);
            end
`endif
        end

        // Reset during KEY frame 2 with another key pending.
        joy_buttons = 8'h24;
        send_key(8'h41);
        read_frame(b, act, tail);
        check("rst_frame1", 32'(b), 32'h41);
        famicom_latch = 1'b1;
        wait_cycles(4);
        check("rst_pre_data",   32'(famicom_data), 32'd0);
        check("rst_pre_active", 32'(key_active),   32'd1);
        famicom_latch = 1'b0;
        wait_cycles(4);
        send_key(8'h42);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("rst_data",   32'(famicom_data), 32'd1);
        check("rst_active", 32'(key_active),   32'd0);
        check("rst_ready",  32'(key_ready),    32'd1);
        reset_n = 1'b1;
        wait_cycles(2);
        read_frame(b, act, tail);
        check("rst_next_byte",   32'(b),   32'hDB);
        check("rst_next_active", 32'(act), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
